// File: rtl/blood_digit_controller.sv
// blood_digit_controller: two-digit blood-sprite health readout with a subtract-based BCD converter.
// Optional low-health blink is enabled by defining BLOOD_LOW_BLINK_EN.
module blood_digit_controller #(
  parameter logic [9:0]  X0           = 10'd32,
  parameter logic [9:0]  Y0           = 10'd16,
  parameter logic [6:0]  MAX_HEALTH   = 7'd99,
  parameter logic [11:0] TRANSPARENT  = 12'h000,
  parameter logic [6:0]  LOW_THRESH   = 7'd20,
  parameter logic [4:0]  BLINK_FRAMES = 5'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  health_in,
  input  logic        health_load,
  output logic        busy,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_tick,
  output logic [3:0]  rom_digit_sel,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  input  logic [11:0] rom_color,
  output logic [11:0] rgb_out,
  output logic        rgb_valid
);
  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_nx;
  logic [6:0] work;
  logic [3:0] tens_work, disp_tens, disp_ones;
  logic [9:0] dx, dy;
  logic in_reg, left, blank, in_reg_d, blank_d, blink_gate, vis;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && health_load) state_nx = CONV;
    if (state == CONV && work < 7'd10) state_nx = IDLE;
  end
  assign busy = state == CONV;
  // Displayed digits only change at commit, so partial results never reach the screen.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      work      <= 7'd0;
      tens_work <= 4'd0;
      disp_tens <= 4'd0;
      disp_ones <= 4'd0;
    end else if (state == IDLE && health_load) begin
      work      <= health_in > MAX_HEALTH ? MAX_HEALTH : health_in;
      tens_work <= 4'd0;
    end else if (state == CONV) begin
      if (work >= 7'd10) begin
        work      <= work - 7'd10;
        tens_work <= tens_work + 4'd1;
      end else begin
        disp_tens <= tens_work;
        disp_ones <= work[3:0];
      end
    end
  // Wrapping subtraction folds the below-origin case into the single upper-bound compare.
  assign dx = pixel_x - X0;
  assign dy = pixel_y - Y0;
  assign in_reg = video_on && dx < 10'd128 && dy < 10'd64;
  assign left = dx < 10'd64;
  assign blank = in_reg && left && disp_tens == 4'd0;
  assign rom_digit_sel = in_reg ? (left ? disp_tens : disp_ones) : 4'd0;
  assign rom_row = in_reg ? dy[5:0] : 6'd0;
  assign rom_col = in_reg ? dx[5:0] : 6'd0;
`ifdef BLOOD_LOW_BLINK_EN
  logic [4:0] frame_cnt;
  logic [6:0] disp_val;
  logic low, blink_off;
  assign disp_val = {3'd0, disp_tens} * 7'd10 + {3'd0, disp_ones};
  assign low = disp_val < LOW_THRESH;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      frame_cnt <= 5'd0;
      blink_off <= 1'b0;
    end else begin
      if (frame_tick) frame_cnt <= frame_cnt == BLINK_FRAMES - 5'd1 ? 5'd0 : frame_cnt + 5'd1;
      if (!low) blink_off <= 1'b0;
      else if (frame_tick && frame_cnt == BLINK_FRAMES - 5'd1) blink_off <= ~blink_off;
    end
  assign blink_gate = low && blink_off;
`else
  logic unused;
  assign unused = ^{frame_tick, LOW_THRESH, BLINK_FRAMES};
  assign blink_gate = 1'b0;
`endif
  assign vis = in_reg_d && !blank_d && rom_color != TRANSPARENT && !blink_gate;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in_reg_d  <= 1'b0;
      blank_d   <= 1'b0;
      rgb_valid <= 1'b0;
      rgb_out   <= 12'h000;
    end else begin
      in_reg_d  <= in_reg;
      blank_d   <= blank;
      rgb_valid <= vis;
      rgb_out   <= vis ? rom_color : 12'h000;
    end
endmodule

// File: tb/tb_blood_digit_controller.sv
// tb_blood_digit_controller: directed, table-driven check of conversion, addressing and the 2-cycle pixel path.
module tb_blood_digit_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  health_in;
  logic        health_load;
  logic        busy;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, frame_tick;
  logic [3:0]  rom_digit_sel;
  logic [5:0]  rom_row, rom_col;
  logic [11:0] rom_color, rgb_out;
  logic        rgb_valid;
  int checks = 0;
  int failures = 0;

  blood_digit_controller dut (
    .clk(clk), .reset(reset), .health_in(health_in), .health_load(health_load), .busy(busy),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .frame_tick(frame_tick),
    .rom_digit_sel(rom_digit_sel), .rom_row(rom_row), .rom_col(rom_col),
    .rom_color(rom_color), .rgb_out(rgb_out), .rgb_valid(rgb_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  h;
    logic [9:0]  x, y;
    logic        v;
    logic [11:0] c;
    logic [3:0]  sel;
    logic [5:0]  row, col;
    logic        val;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load a health value and count busy cycles; optionally pulse a second load while busy.
  task automatic load(input logic [6:0] h, input logic dup, output int n);
    @(posedge clk); #1;
    health_in = h;
    health_load = 1'b1;
    @(posedge clk); #1;
    health_load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      health_load = dup && n == 0;
      if (dup) health_in = 7'd5;
      n++;
      @(posedge clk); #1;
    end
    health_load = 1'b0;
  endtask

  // Present an address in cycle N, drive ROM data in N+1, check registered output after N+2.
  task automatic pix(input vec_t t, input string tag);
    @(posedge clk); #1;
    pixel_x = t.x; pixel_y = t.y; video_on = t.v; rom_color = 12'h000;
    #1;
    chk({tag, "_sel"}, 32'(rom_digit_sel), 32'(t.sel));
    chk({tag, "_row"}, 32'(rom_row), 32'(t.row));
    chk({tag, "_col"}, 32'(rom_col), 32'(t.col));
    @(posedge clk); #1;
    pixel_x = 10'd0; pixel_y = 10'd0; rom_color = t.c;
    @(posedge clk); #1;
    rom_color = 12'h000;
    chk({tag, "_valid"}, 32'(rgb_valid), 32'(t.val));
    chk({tag, "_rgb"}, 32'(rgb_out), 32'(t.rgb));
  endtask

  initial begin
    int n;
    logic [6:0] cur;
    vec_t t;
    vecs[0]  = '{7'd87, 10'd102, 10'd21, 1'b1, 12'hABC, 4'd7, 6'd5, 6'd6, 1'b1, 12'hABC};
    vecs[1]  = '{7'd87, 10'd32, 10'd16, 1'b1, 12'h123, 4'd8, 6'd0, 6'd0, 1'b1, 12'h123};
    vecs[2]  = '{7'd87, 10'd159, 10'd79, 1'b1, 12'hFFF, 4'd7, 6'd63, 6'd63, 1'b1, 12'hFFF};
    vecs[3]  = '{7'd87, 10'd31, 10'd16, 1'b1, 12'hFFF, 4'd0, 6'd0, 6'd0, 1'b0, 12'h000};
    vecs[4]  = '{7'd87, 10'd160, 10'd16, 1'b1, 12'hFFF, 4'd0, 6'd0, 6'd0, 1'b0, 12'h000};
    vecs[5]  = '{7'd87, 10'd32, 10'd80, 1'b1, 12'hFFF, 4'd0, 6'd0, 6'd0, 1'b0, 12'h000};
    vecs[6]  = '{7'd87, 10'd50, 10'd20, 1'b0, 12'hFFF, 4'd0, 6'd0, 6'd0, 1'b0, 12'h000};
    vecs[7]  = '{7'd87, 10'd95, 10'd16, 1'b1, 12'h0F0, 4'd8, 6'd0, 6'd63, 1'b1, 12'h0F0};
    vecs[8]  = '{7'd87, 10'd96, 10'd16, 1'b1, 12'h00F, 4'd7, 6'd0, 6'd0, 1'b1, 12'h00F};
    vecs[9]  = '{7'd87, 10'd100, 10'd20, 1'b1, 12'h000, 4'd7, 6'd4, 6'd4, 1'b0, 12'h000};
    vecs[10] = '{7'd5, 10'd40, 10'd20, 1'b1, 12'hFFF, 4'd0, 6'd4, 6'd8, 1'b0, 12'h000};
    vecs[11] = '{7'd5, 10'd110, 10'd20, 1'b1, 12'hE00, 4'd5, 6'd4, 6'd14, 1'b1, 12'hE00};
    vecs[12] = '{7'd5, 10'd110, 10'd20, 1'b1, 12'h000, 4'd5, 6'd4, 6'd14, 1'b0, 12'h000};
    vecs[13] = '{7'd0, 10'd40, 10'd20, 1'b1, 12'hFFF, 4'd0, 6'd4, 6'd8, 1'b0, 12'h000};
    vecs[14] = '{7'd0, 10'd100, 10'd20, 1'b1, 12'hFFF, 4'd0, 6'd4, 6'd4, 1'b1, 12'hFFF};
    vecs[15] = '{7'd40, 10'd40, 10'd20, 1'b1, 12'h321, 4'd4, 6'd4, 6'd8, 1'b1, 12'h321};
    reset = 1'b1; health_in = 7'd0; health_load = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0; frame_tick = 1'b0; rom_color = 12'h000;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rgb_valid), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cur = 7'd0;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].h != cur) begin
        load(vecs[i].h, 1'b0, n);
        chk($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].h / 10 + 1));
        cur = vecs[i].h;
      end
      pix(vecs[i], $sformatf("v%0d", i));
    end
    // Saturation plus a load during busy that must be dropped.
    load(7'd120, 1'b1, n);
    chk("sat_busy_cycles", 32'(n), 32'd10);
    t = '{7'd99, 10'd40, 10'd20, 1'b1, 12'h555, 4'd9, 6'd4, 6'd8, 1'b1, 12'h555};
    pix(t, "sat_left");
    t = '{7'd99, 10'd100, 10'd20, 1'b1, 12'h555, 4'd9, 6'd4, 6'd4, 1'b1, 12'h555};
    pix(t, "sat_right");
`ifdef BLOOD_LOW_BLINK_EN
    load(7'd15, 1'b0, n);
    t = '{7'd15, 10'd100, 10'd20, 1'b1, 12'hE00, 4'd5, 6'd4, 6'd4, 1'b1, 12'hE00};
    for (int f = 0; f < 32; f++) begin
      t.val = f < 16;
      t.rgb = f < 16 ? 12'hE00 : 12'h000;
      pix(t, $sformatf("blink15_f%0d", f));
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
    load(7'd50, 1'b0, n);
    t = '{7'd50, 10'd100, 10'd20, 1'b1, 12'hE00, 4'd0, 6'd4, 6'd4, 1'b1, 12'hE00};
    for (int f = 0; f < 32; f++) begin
      pix(t, $sformatf("blink50_f%0d", f));
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
`endif
    // Asynchronous reset mid-conversion with an opaque pixel in flight.
    load(7'd87, 1'b0, n);
    pixel_x = 10'd102; pixel_y = 10'd21; video_on = 1'b1; rom_color = 12'hABC;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_valid", 32'(rgb_valid), 32'd1);
    health_in = 7'd50; health_load = 1'b1;
    @(posedge clk); #1;
    health_load = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(rgb_valid), 32'd0);
    chk("arst_rgb", 32'(rgb_out), 32'd0);
    chk("arst_ones", 32'(rom_digit_sel), 32'd0);
    pixel_x = 10'd40;
    #1;
    chk("arst_tens", 32'(rom_digit_sel), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
